// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a 4-register window feeding a circular TX FIFO
// that drains into an 8N1 serializer with a programmable clocks-per-bit divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter int          DIV       = 16,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic        tx
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic [15:0]   divisor;

  state_t        state;
  logic [7:0]    shift_reg;
  logic [15:0]   baud_cnt;
  logic [15:0]   div_lat;
  logic [2:0]    bit_idx;

  logic [1:0]    offset;
  logic          empty, full, busy;
  logic          wr_txdata, wr_status, wr_divisor;
  logic          push, pop, baud_done;
  logic [15:0]   div_eff;
  logic          unused_ok;

  assign hit    = (address_to_mem[31:4] == BASE_ADDR[31:4]);
  assign offset = address_to_mem[3:2];

  assign empty = (count == 5'd0);
  assign full  = (count == 5'(DEPTH));
  assign busy  = (state != IDLE);

  assign wr_txdata  = WE && hit && (offset == OFF_TXDATA);
  assign wr_status  = WE && hit && (offset == OFF_STATUS);
  assign wr_divisor = WE && hit && (offset == OFF_DIVISOR);

  // Full is judged on the pre-edge count, so a pop in the same cycle never rescues a push.
  assign push      = wr_txdata && !full;
  assign baud_done = (baud_cnt == div_lat - 16'd1);
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
  assign div_eff   = (divisor < 16'd2) ? 16'd2 : divisor;

  assign unused_ok = ^{data_to_mem[31:16], address_to_mem[1:0]};

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (offset)
        OFF_STATUS:  rd_data = {20'b0, count[3:0], 4'b0, overflow, busy, full, empty};
        OFF_DIVISOR: rd_data = {16'b0, divisor};
        default:     rd_data = '0;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_to_mem[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      divisor  <= 16'(DIV);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 5'd1;
      else if (!push && pop) count <= count - 5'd1;
      if (wr_txdata && full)                overflow <= 1'b1;
      else if (wr_status && data_to_mem[3]) overflow <= 1'b0;
      if (wr_divisor) divisor <= data_to_mem[15:0];
    end
  end

  // Serializer; tx is registered so it changes only on the edge that changes state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shift_reg <= '0;
      baud_cnt  <= '0;
      div_lat   <= 16'd2;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            div_lat   <= div_eff;
            baud_cnt  <= '0;
            state     <= START;
            tx        <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr];
              div_lat   <= div_eff;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table plus hand-written
// frame, overflow, divisor and reset sequences with bit-by-bit tx expectations.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] rd_data;
  logic        hit;
  logic        tx;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A_TXDATA  = 32'h0000_F000;
  localparam logic [31:0] A_STATUS  = 32'h0000_F004;
  localparam logic [31:0] A_DIVISOR = 32'h0000_F008;

  mmio_uart_tx #(.BASE_ADDR(32'h0000_F000), .DIV(16), .DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .rd_data        (rd_data),
    .hit            (hit),
    .tx             (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1;
    address_to_mem = a;
    data_to_mem = d;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    WE = 1'b0;
    address_to_mem = a;
    #1;
    check(name, rd_data, exp);
  endtask

  // Expected line level j clocks into a frame of byte b at div clocks per bit.
  function automatic logic exp_bit(input logic [7:0] b, input int j, input int div);
    int idx;
    idx = j / div;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Called at the negedge that follows frame sample `first`; optionally pushes on the frame's last edge.
  task automatic check_frame(input logic [7:0] b, input int div, input int first,
                             input logic push_last, input logic [7:0] push_val);
    for (int j = first; j < 10 * div; j++) begin
      check($sformatf("frame_%h_t%0d", b, j), {31'b0, tx}, {31'b0, exp_bit(b, j, div)});
      if (push_last && (j == 10 * div - 1)) begin
        WE = 1'b1;
        address_to_mem = A_TXDATA;
        data_to_mem = {24'b0, push_val};
      end
      @(negedge clk);
      WE = 1'b0;
    end
  endtask

  initial begin
    // Register map exercised with the serializer idle and divisor at its reset value.
    vecs[0]  = '{1'b0, 32'h0000_F004, 32'h0,         32'h0000_0001, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000_F008, 32'h0,         32'h0000_0010, 1'b1};
    vecs[2]  = '{1'b1, 32'h0000_F008, 32'hABCD_0025, 32'h0000_0010, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_F008, 32'h0,         32'h0000_0025, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_F00B, 32'h0,         32'h0000_0025, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_F001, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_F00C, 32'h0,         32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_F00C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_F004, 32'h0,         32'h0000_0001, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_E008, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_F008, 32'h0,         32'h0000_0025, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_E004, 32'h0,         32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h1000_F004, 32'h0,         32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_F004, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[14] = '{1'b0, 32'h0000_F004, 32'h0,         32'h0000_0001, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_E000, 32'h0000_0077, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_F004, 32'h0,         32'h0000_0001, 1'b1};
    vecs[17] = '{1'b1, 32'h0000_F008, 32'h0000_0010, 32'h0000_0025, 1'b1};
    vecs[18] = '{1'b0, 32'h0000_F008, 32'h0,         32'h0000_0010, 1'b1};

    reset = 1'b0;
    WE = 1'b0;
    address_to_mem = '0;
    data_to_mem = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'h1);
    check_reg("reset_status", A_STATUS, 32'h0000_0001);
    check_reg("reset_divisor", A_DIVISOR, 32'h0000_0010);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      WE = vecs[i].we;
      address_to_mem = vecs[i].addr;
      data_to_mem = vecs[i].data;
      #1;
      check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      @(negedge clk);
    end
    WE = 1'b0;

    // Single 0x55 frame at 16 clocks per bit, with one-edge start latency.
    bus_write(A_TXDATA, 32'h55);
    check("latency_tx_still_high", {31'b0, tx}, 32'h1);
    @(negedge clk);
    check_frame(8'h55, 16, 0, 1'b0, 8'h00);
    check_reg("after_55_status", A_STATUS, 32'h0000_0001);

    // Nine back-to-back writes fill the FIFO; the tenth overflows.
    for (int i = 1; i <= 9; i++) bus_write(A_TXDATA, i);
    check_reg("fill_status", A_STATUS, 32'h0000_0806);
    bus_write(A_TXDATA, 32'hAA);
    check_reg("overflow_status", A_STATUS, 32'h0000_080E);
    bus_write(A_STATUS, 32'h8);
    check_reg("ovf_clear_full", A_STATUS, 32'h0000_0806);
    // A push on the same edge as the pop that frees a slot must still be dropped.
    check_frame(8'h01, 16, 9, 1'b1, 8'hEE);
    check_reg("push_on_pop_status", A_STATUS, 32'h0000_070C);
    for (int i = 2; i <= 9; i++) check_frame(8'(i), 16, 0, 1'b0, 8'h00);
    check_reg("drain_status", A_STATUS, 32'h0000_0009);
    bus_write(A_STATUS, 32'h8);
    check_reg("ovf_clear_empty", A_STATUS, 32'h0000_0001);

    // Divisor 0 is clamped to 2; a mid-frame divisor write applies to the next frame.
    bus_write(A_DIVISOR, 32'h0);
    check_reg("div0_readback", A_DIVISOR, 32'h0000_0000);
    bus_write(A_TXDATA, 32'h3C);
    check("div0_latency_high", {31'b0, tx}, 32'h1);
    bus_write(A_TXDATA, 32'hC5);
    check("div0_start_low", {31'b0, tx}, 32'h0);
    bus_write(A_DIVISOR, 32'h3);
    check_frame(8'h3C, 2, 1, 1'b0, 8'h00);
    check_frame(8'hC5, 3, 0, 1'b0, 8'h00);
    check_reg("div3_idle_status", A_STATUS, 32'h0000_0001);
    check_reg("div3_readback", A_DIVISOR, 32'h0000_0003);

    // Reset during data bit 4 with three bytes queued, colliding with a DIVISOR write.
    bus_write(A_DIVISOR, 32'd20);
    bus_write(A_TXDATA, 32'h11);
    bus_write(A_TXDATA, 32'h22);
    bus_write(A_TXDATA, 32'h33);
    bus_write(A_TXDATA, 32'h44);
    repeat (100) @(negedge clk);
    check("pre_reset_bit4", {31'b0, tx}, {31'b0, exp_bit(8'h11, 102, 20)});
    check_reg("pre_reset_count", A_STATUS, 32'h0000_0304);
    reset = 1'b0;
    WE = 1'b1;
    address_to_mem = A_DIVISOR;
    data_to_mem = 32'h5;
    @(negedge clk);
    reset = 1'b1;
    WE = 1'b0;
    check("midframe_reset_tx", {31'b0, tx}, 32'h1);
    check_reg("midframe_reset_status", A_STATUS, 32'h0000_0001);
    check_reg("midframe_reset_divisor", A_DIVISOR, 32'h0000_0010);
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle_t%0d", i), {31'b0, tx}, 32'h1);
    end
    check_reg("post_reset_status", A_STATUS, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_F000, SHALL set the 16-byte-aligned base of the register window.
REQ-002 Parameter DIV, default 16, SHALL set the reset value of the clocks-per-bit divisor.
REQ-003 Parameter DEPTH, default 8, SHALL set the TX FIFO depth; the value SHALL be a power of two, 2..16.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 reset  input  1  SHALL be synchronous, active-low: a sample of 0 at posedge clk resets the block.
REQ-006 WE  input  1  SHALL be the processor data-port write enable.
REQ-007 address_to_mem  input  32  SHALL be the processor data address.
REQ-008 data_to_mem  input  32  SHALL be the processor store data.
REQ-009 rd_data  output  32  SHALL be the combinational read data for the addressed register.
REQ-010 hit  output  1  SHALL be combinational; 1 iff address_to_mem[31:4] == BASE_ADDR[31:4].
REQ-011 tx  output  1  SHALL be the serial line output, idle high.

Function
REQ-012 Register offsets SHALL be decoded from address_to_mem[3:2]; bits [1:0] are ignored.
REQ-013 Offset 0x0 TXDATA: a write with WE=1 and hit=1 SHALL push data_to_mem[7:0] into the FIFO; a read SHALL return 0.
REQ-014 Offset 0x4 STATUS: a read SHALL return {20'b0, count[3:0], 4'b0, overflow, busy, full, empty}.
REQ-015 Offset 0x4 STATUS: a write with data_to_mem[3]=1 SHALL clear overflow (write-1-to-clear); other bits are ignored.
REQ-016 Offset 0x8 DIVISOR: reads SHALL return {16'b0, divisor}; writes SHALL load data_to_mem[15:0].
REQ-017 Offset 0xC SHALL read as 0 and ignore writes; rd_data SHALL be 0 whenever hit=0.
REQ-018 The FIFO SHALL be circular with wrapping read/write pointers and count 0..DEPTH; empty=(count==0); full=(count==DEPTH).
REQ-019 Full SHALL be evaluated before the edge: a TXDATA write while full SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-021 The serializer FSM SHALL have states IDLE, START, DATA, STOP; busy SHALL equal (state != IDLE).
REQ-022 In IDLE with empty=0, the next edge SHALL pop the head into an 8-bit shift register, latch the divisor, zero the baud counter, and enter START.
REQ-023 START, each of the 8 DATA bits, and STOP SHALL each last exactly the latched divisor clocks; DATA SHALL shift LSB first.
REQ-024 tx SHALL be a Moore output: 1 in IDLE and STOP, 0 in START, shift_reg[0] in DATA.
REQ-025 On the final STOP cycle, if empty=0, the FSM SHALL pop and enter START directly, so back-to-back frames are exactly 10*divisor cycles apart; otherwise it SHALL enter IDLE.
REQ-026 A divisor below 2 SHALL be latched as 2; a DIVISOR write mid-frame SHALL take effect only at the next frame start.
REQ-027 Latency: a TXDATA write at edge k into an empty FIFO with the FSM in IDLE SHALL drive tx low after edge k+1.

Reset
REQ-028 While reset=0 at an edge: FIFO pointers and count SHALL clear, overflow=0, divisor=DIV, state=IDLE, and tx=1 after that edge.
REQ-029 A reset mid-frame SHALL abort the frame and discard all queued bytes, with no partial frame resumed after reset.
REQ-030 Reset SHALL take priority over any simultaneous register write.

Verification
REQ-031 Scenario: DIV=16; write 0x55 to TXDATA -> tx low one cycle after the write edge, then bits 1,0,1,0,1,0,1,0 with 16 clocks each, then stop high; busy=0 after 160 clocks.
REQ-032 Scenario: 9 back-to-back writes 0x01..0x09 with DEPTH=8 -> the 9th is accepted because the first pop frees a slot; a further write while full sets STATUS bit3; frames are contiguous at 160-clock spacing.
REQ-033 Scenario: write STATUS 0x8 after overflow -> bit3 reads 0; count and empty are unchanged.
REQ-034 Scenario: write DIVISOR 0 -> reads back 0; the next frame uses 2 clocks per bit (20 clocks per frame).
REQ-035 Scenario: assert reset at bit 4 of a frame with 3 bytes queued -> tx=1, STATUS reads 0x1, DIVISOR reads 16.
REQ-036 Scenario: read offset 0xC and a non-matching address -> rd_data=0; hit=0 for the non-matching address.
